// File: rtl/decode_pkg.sv
// RV32I decode types: opcodes, format tag and the decoded entry handed to rename/dispatch.
// No logic here; latency and backpressure belong to the stages that use these types.
package decode_pkg;

    localparam int XLEN       = 32;
    localparam int INSN_WIDTH = 32;
    localparam int PC_WIDTH   = 32;
    localparam int NUM_REGS   = 32;
    localparam int ADDR_WIDTH = $clog2(NUM_REGS);

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_R       = 3'd0,
        FMT_I       = 3'd1,
        FMT_S       = 3'd2,
        FMT_B       = 3'd3,
        FMT_U       = 3'd4,
        FMT_J       = 3'd5,
        FMT_ILLEGAL = 3'd6
    } fmt_e;

    typedef struct packed {
        logic [PC_WIDTH-1:0]   pc;
        logic [6:0]            opcode;
        logic [2:0]            funct3;
        logic [6:0]            funct7;
        logic [ADDR_WIDTH-1:0] rs1;
        logic [ADDR_WIDTH-1:0] rs2;
        logic [ADDR_WIDTH-1:0] rd;
        logic [XLEN-1:0]       imm;
        fmt_e                  fmt;
        logic                  rs1_used;
        logic                  rs2_used;
        logic                  rd_write;
        logic                  illegal;
    } decoded_t;

    // Every legal opcode already ends in 2'b11, so the compressed-space check falls out of the default.
    function automatic fmt_e opcode_fmt(input logic [6:0] opc);
        fmt_e f;
        case (opc)
            OPC_LUI, OPC_AUIPC:                  f = FMT_U;
            OPC_JAL:                             f = FMT_J;
            OPC_JALR, OPC_LOAD, OPC_OP_IMM,
            OPC_MISC_MEM, OPC_SYSTEM:            f = FMT_I;
            OPC_BRANCH:                          f = FMT_B;
            OPC_STORE:                           f = FMT_S;
            OPC_OP:                              f = FMT_R;
            default:                             f = FMT_ILLEGAL;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-to-decode and decode-to-regread handshake bundle; slave side is the decode stage.
// Carries valid/ready on both sides plus the flush from the redirect logic.
interface decode_stage_if import decode_pkg::*; ();

    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [INSN_WIDTH-1:0] in_insn;
    logic [PC_WIDTH-1:0]   in_pc;

    logic                  out_valid;
    logic                  out_ready;
    logic [PC_WIDTH-1:0]   out_pc;
    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [ADDR_WIDTH-1:0] rs1;
    logic [ADDR_WIDTH-1:0] rs2;
    logic [ADDR_WIDTH-1:0] rd;
    logic [XLEN-1:0]       imm;
    fmt_e                  fmt;
    logic                  rs1_used;
    logic                  rs2_used;
    logic                  rd_write;
    logic                  illegal;

    modport master (
        output flush, in_valid, in_insn, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, opcode, funct3, funct7, rs1, rs2, rd,
               imm, fmt, rs1_used, rs2_used, rd_write, illegal
    );

    modport slave (
        input  flush, in_valid, in_insn, in_pc, out_ready,
        output in_ready, out_valid, out_pc, opcode, funct3, funct7, rs1, rs2, rd,
               imm, fmt, rs1_used, rs2_used, rd_write, illegal
    );

endinterface

// File: rtl/decode_stage_imm_gen.sv
// Immediate generator: instruction bits + format tag -> sign-extended immediate.
// Purely combinational, no handshake.
module imm_gen
    import decode_pkg::*;
(
    input  logic [31:7]     insn,
    input  fmt_e            fmt,
    output logic [XLEN-1:0] imm
);

    logic signed [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (fmt)
            FMT_I:   imm32 = {{20{insn[31]}}, insn[31:20]};
            FMT_S:   imm32 = {{20{insn[31]}}, insn[31:25], insn[11:7]};
            FMT_B:   imm32 = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
            FMT_U:   imm32 = {insn[31:12], 12'b0};
            FMT_J:   imm32 = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    // Signed size cast sign-extends for any XLEN >= 32.
    assign imm = XLEN'(imm32);

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage between fetch and register read; registered output plus one skid entry.
// Latency 1 cycle; in_ready is a flop (low only when both entries are full), so no out_ready->in_ready path.
module decode_stage
    import decode_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    decode_stage_if.slave bus
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    state_e          state_q;
    state_e          state_d;
    decoded_t        dec;
    decoded_t        out_q;
    decoded_t        out_d;
    decoded_t        skid_q;
    decoded_t        skid_d;
    logic            in_ready_q;
    logic            accept;
    logic            drain;
    fmt_e            fmt;
    logic [XLEN-1:0] imm;

    assign fmt = opcode_fmt(bus.in_insn[6:0]);

    imm_gen u_imm_gen (
        .insn (bus.in_insn[31:7]),
        .fmt  (fmt),
        .imm  (imm)
    );

    always_comb begin
        dec          = '0;
        dec.pc       = bus.in_pc;
        dec.opcode   = bus.in_insn[6:0];
        dec.funct3   = bus.in_insn[14:12];
        dec.funct7   = bus.in_insn[31:25];
        dec.rs1      = bus.in_insn[19:15];
        dec.rs2      = bus.in_insn[24:20];
        dec.rd       = bus.in_insn[11:7];
        dec.imm      = imm;
        dec.fmt      = fmt;
        dec.illegal  = (fmt == FMT_ILLEGAL);
        dec.rs1_used = (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_S) || (fmt == FMT_B);
        dec.rs2_used = (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B);
        dec.rd_write = ((fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_U) || (fmt == FMT_J))
                       && (bus.in_insn[11:7] != '0);
    end

    // A flushed cycle never accepts; a flushed head is never counted as drained.
    assign accept = bus.in_valid && bus.in_ready && !bus.flush;
    assign drain  = (state_q != ST_EMPTY) && bus.out_ready && !bus.flush;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_ONE;
                    out_d   = dec;
                end
            end
            ST_ONE: begin
                if (accept && drain) begin
                    out_d = dec;
                end else if (accept) begin
                    state_d = ST_TWO;
                    skid_d  = dec;
                end else if (drain) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (drain) begin
                    state_d = ST_ONE;
                    out_d   = skid_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (bus.flush) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
            out_q      <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_TWO);
            out_q      <= out_d;
            skid_q     <= skid_d;
        end
    end

    // Gated by rst_n so fetch sees not-ready for as long as reset is held.
    assign bus.in_ready  = in_ready_q && rst_n;
    assign bus.out_valid = (state_q != ST_EMPTY);
    assign bus.out_pc    = out_q.pc;
    assign bus.opcode    = out_q.opcode;
    assign bus.funct3    = out_q.funct3;
    assign bus.funct7    = out_q.funct7;
    assign bus.rs1       = out_q.rs1;
    assign bus.rs2       = out_q.rs2;
    assign bus.rd        = out_q.rd;
    assign bus.imm       = out_q.imm;
    assign bus.fmt       = out_q.fmt;
    assign bus.rs1_used  = out_q.rs1_used;
    assign bus.rs2_used  = out_q.rs2_used;
    assign bus.rd_write  = out_q.rd_write;
    assign bus.illegal   = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed spec cases, skid/flush/reset sequences and random traffic,
// all checked by a scoreboard fed from an arithmetic reference model.
module tb_decode_stage;
    import decode_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    decode_stage_if dif ();

    decode_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif.slave)
    );

    int       vectors = 0;
    int       miscompares = 0;
    decoded_t exp_q[$];

    function automatic decoded_t model(input logic [31:0] w, input logic [31:0] pc);
        decoded_t d;
        int       v;
        fmt_e     f;
        d        = '0;
        d.pc     = pc;
        d.opcode = w[6:0];
        d.funct3 = w[14:12];
        d.funct7 = w[31:25];
        d.rs1    = w[19:15];
        d.rs2    = w[24:20];
        d.rd     = w[11:7];
        case (w[6:0])
            7'h37, 7'h17:                      f = FMT_U;
            7'h6F:                             f = FMT_J;
            7'h67, 7'h03, 7'h13, 7'h0F, 7'h73: f = FMT_I;
            7'h63:                             f = FMT_B;
            7'h23:                             f = FMT_S;
            7'h33:                             f = FMT_R;
            default:                           f = FMT_ILLEGAL;
        endcase
        v = 0;
        case (f)
            FMT_I: v = int'(w[31:20]) - (w[31] ? 4096 : 0);
            FMT_S: v = int'(w[31:25]) * 32 + int'(w[11:7]) - (w[31] ? 4096 : 0);
            FMT_B: v = int'(w[11:8]) * 2 + int'(w[30:25]) * 32 + int'(w[7]) * 2048
                       - (w[31] ? 4096 : 0);
            FMT_U: v = int'(w[31:12]) * 4096;
            FMT_J: v = int'(w[30:21]) * 2 + int'(w[20]) * 2048 + int'(w[19:12]) * 4096
                       - (w[31] ? 1048576 : 0);
            default: v = 0;
        endcase
        d.imm      = v;
        d.fmt      = f;
        d.illegal  = (f == FMT_ILLEGAL);
        d.rs1_used = (f == FMT_R) || (f == FMT_I) || (f == FMT_S) || (f == FMT_B);
        d.rs2_used = (f == FMT_R) || (f == FMT_S) || (f == FMT_B);
        d.rd_write = ((f == FMT_R) || (f == FMT_I) || (f == FMT_U) || (f == FMT_J)) && (w[11:7] != 0);
        return d;
    endfunction

    function automatic logic [31:0] rand_insn();
        logic [31:0] w;
        w = $urandom();
        case ($urandom_range(0, 13))
            0:  w[6:0] = 7'h37;
            1:  w[6:0] = 7'h17;
            2:  w[6:0] = 7'h6F;
            3:  w[6:0] = 7'h67;
            4:  w[6:0] = 7'h63;
            5:  w[6:0] = 7'h03;
            6:  w[6:0] = 7'h23;
            7:  w[6:0] = 7'h13;
            8:  w[6:0] = 7'h33;
            9:  w[6:0] = 7'h0F;
            10: w[6:0] = 7'h73;
            default: ;
        endcase
        return w;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // One cycle of stimulus; returns at the negedge with acceptance already decided.
    task automatic step(input logic v, input logic [31:0] insn, input logic [31:0] pc,
                        input logic ordy, input logic fl, output logic acc);
        @(posedge clk);
        #1;
        dif.in_valid  = v;
        dif.in_insn   = insn;
        dif.in_pc     = pc;
        dif.out_ready = ordy;
        dif.flush     = fl;
        @(negedge clk);
        acc = v && dif.in_ready && !fl && rst_n;
        if (acc) exp_q.push_back(model(insn, pc));
    endtask

    always @(negedge clk) begin
        decoded_t a;
        decoded_t e;
        if (!rst_n || dif.flush) begin
            exp_q.delete();
        end else if (dif.out_valid && dif.out_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_output: got pc=0x%0h, required no output", dif.out_pc);
            end else begin
                e          = exp_q.pop_front();
                a          = '0;
                a.pc       = dif.out_pc;
                a.opcode   = dif.opcode;
                a.funct3   = dif.funct3;
                a.funct7   = dif.funct7;
                a.rs1      = dif.rs1;
                a.rs2      = dif.rs2;
                a.rd       = dif.rd;
                a.imm      = dif.imm;
                a.fmt      = dif.fmt;
                a.rs1_used = dif.rs1_used;
                a.rs2_used = dif.rs2_used;
                a.rd_write = dif.rd_write;
                a.illegal  = dif.illegal;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL scoreboard: got pc=%h imm=%h fmt=%0d flags=%b%b%b%b rd=%0d, required pc=%h imm=%h fmt=%0d flags=%b%b%b%b rd=%0d",
                             a.pc, a.imm, a.fmt, a.rs1_used, a.rs2_used, a.rd_write, a.illegal, a.rd,
                             e.pc, e.imm, e.fmt, e.rs1_used, e.rs2_used, e.rd_write, e.illegal, e.rd);
                end
            end
        end
    end

    task automatic directed(input string nm, input logic [31:0] insn, input logic [31:0] pc,
                            input fmt_e f, input logic [31:0] imm, input logic ill);
        logic acc;
        step(1'b1, insn, pc, 1'b1, 1'b0, acc);
        chk({nm, "_accept"}, acc, 1);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
        chk({nm, "_out_valid"}, dif.out_valid, 1);
        chk({nm, "_fmt"}, dif.fmt, f);
        chk({nm, "_imm"}, dif.imm, imm);
        chk({nm, "_illegal"}, dif.illegal, ill);
        chk({nm, "_out_pc"}, dif.out_pc, pc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acc;
        logic        have;
        logic        v;
        logic        ordy;
        logic        fl;
        logic [31:0] cur_insn;
        logic [31:0] cur_pc;

        dif.flush = 1'b0; dif.in_valid = 1'b0; dif.in_insn = '0; dif.in_pc = '0; dif.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", dif.out_valid, 0);
        chk("rst_in_ready", dif.in_ready, 0);
        chk("rst_out_pc", dif.out_pc, 0);
        chk("rst_imm", dif.imm, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", dif.in_ready, 1);

        directed("addi", 32'hFFF00093, 32'h0000_1000, FMT_I, 32'hFFFF_FFFF, 1'b0);
        chk("addi_rd", dif.rd, 1);
        chk("addi_rs1", dif.rs1, 0);
        chk("addi_rd_write", dif.rd_write, 1);
        chk("addi_rs2_used", dif.rs2_used, 0);
        directed("sw", 32'h0020A423, 32'h0000_1004, FMT_S, 32'h0000_0008, 1'b0);
        chk("sw_rs1", dif.rs1, 1);
        chk("sw_rs2", dif.rs2, 2);
        chk("sw_rd_write", dif.rd_write, 0);
        chk("sw_funct3", dif.funct3, 2);
        directed("beq", 32'hFE000EE3, 32'h0000_1008, FMT_B, 32'hFFFF_FFFC, 1'b0);
        directed("lui", 32'h123452B7, 32'h0000_100C, FMT_U, 32'h1234_5000, 1'b0);
        directed("zero_insn", 32'h0000_0000, 32'h0000_2000, FMT_ILLEGAL, 32'h0, 1'b1);
        directed("opc_7f", 32'hFFFF_FFFF, 32'h0000_2004, FMT_ILLEGAL, 32'h0, 1'b1);
        chk("opc_7f_rs1_used", dif.rs1_used, 0);
        chk("opc_7f_rd_write", dif.rd_write, 0);

        // Stall with three back-to-back offers: two fit, the third waits.
        step(1'b1, 32'h00100093, 32'h0000_3000, 1'b0, 1'b0, acc);
        chk("skid_acc0", acc, 1);
        step(1'b1, 32'h00200113, 32'h0000_3004, 1'b0, 1'b0, acc);
        chk("skid_acc1", acc, 1);
        step(1'b1, 32'h00300193, 32'h0000_3008, 1'b0, 1'b0, acc);
        chk("skid_acc2_blocked", acc, 0);
        chk("skid_in_ready_two", dif.in_ready, 0);
        chk("skid_head_pc", dif.out_pc, 32'h0000_3000);
        step(1'b1, 32'h00300193, 32'h0000_3008, 1'b0, 1'b0, acc);
        chk("skid_head_held", dif.out_pc, 32'h0000_3000);
        step(1'b1, 32'h00300193, 32'h0000_3008, 1'b1, 1'b0, acc);
        chk("skid_drain_cycle_no_acc", acc, 0);
        step(1'b1, 32'h00300193, 32'h0000_3008, 1'b1, 1'b0, acc);
        chk("skid_in_ready_after_drain", dif.in_ready, 1);
        chk("skid_acc2_late", acc, 1);
        repeat (4) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);

        // Flush while both entries are full, with a concurrent offer.
        step(1'b1, 32'h00400213, 32'h0000_4000, 1'b0, 1'b0, acc);
        step(1'b1, 32'h00500293, 32'h0000_4004, 1'b0, 1'b0, acc);
        step(1'b1, 32'h00600313, 32'h0000_4008, 1'b1, 1'b1, acc);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
        chk("flush_out_valid", dif.out_valid, 0);
        chk("flush_in_ready", dif.in_ready, 1);
        repeat (3) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);

        // Reset while both entries are full.
        step(1'b1, 32'h00700393, 32'h0000_5000, 1'b0, 1'b0, acc);
        step(1'b1, 32'h00800413, 32'h0000_5004, 1'b0, 1'b0, acc);
        rst_n = 1'b0;
        step(1'b1, 32'h00900493, 32'h0000_5008, 1'b1, 1'b0, acc);
        chk("rst_two_out_valid", dif.out_valid, 0);
        chk("rst_two_in_ready", dif.in_ready, 0);
        step(1'b1, 32'h00900493, 32'h0000_5008, 1'b1, 1'b0, acc);
        chk("rst_two_in_ready_held", dif.in_ready, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        dif.in_valid = 1'b0;
        @(negedge clk);
        chk("rst_two_release_in_ready", dif.in_ready, 1);
        chk("rst_two_release_out_valid", dif.out_valid, 0);

        have = 1'b0;
        cur_insn = '0;
        cur_pc = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!have) begin
                cur_insn = rand_insn();
                cur_pc   = $urandom() & 32'hFFFF_FFFC;
                have     = 1'b1;
            end
            v    = ($urandom_range(0, 3) != 0);
            ordy = ((i / 500) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            fl   = ($urandom_range(0, 99) == 0);
            step(v, cur_insn, cur_pc, ordy, fl, acc);
            if (acc) have = 1'b0;
        end

        for (int i = 0; i < 20; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
        chk("final_queue_drained", exp_q.size(), 0);
        chk("final_out_valid", dif.out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
